ex_core_decode_stage: RTL and testbench

Registered RV32I decode stage for ex_core with a parametrised instruction queue in front of it. Fetched instructions are buffered in a DEPTH-entry FIFO, decoded from the FIFO head, and presented through an output register with a valid/ready handshake. Adds full immediate generation, register-index extraction, illegal-instruction detection and pipeline flush. Sits between fetch and the register-file/ALU stages.

---
 rtl/ex_core_decode_stage_if.sv | 36 +++
 rtl/ex_core_decode_stage.sv | 251 +++++++++++++++++++++++++
 tb/tb_ex_core_decode_stage.sv | 361 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ex_core_decode_stage_if.sv
// Handshake bundle between fetch, the ex_core decode stage and the register-file/ALU side.
// The stage itself uses the slave modport; whoever drives fetch and consumes decode uses master.
interface ex_core_decode_stage_if #(
  parameter int PC_W = 32
);
  logic            in_valid;
  logic            in_ready;
  logic [31:0]     in_instr;
  logic [PC_W-1:0] in_pc;

  logic            out_valid;
  logic            out_ready;
  logic [PC_W-1:0] out_pc;
  logic [6:0]      out_opcode;
  logic [2:0]      out_funct3;
  logic [6:0]      out_funct7;
  logic [4:0]      out_rs1;
  logic [4:0]      out_rs2;
  logic [4:0]      out_rd;
  logic [31:0]     out_imm;
  logic [3:0]      out_alu_op;
  logic            out_reg_wr_en;
  logic            out_illegal;

  modport master (
    output in_valid, in_instr, in_pc, out_ready,
    input  in_ready, out_valid, out_pc, out_opcode, out_funct3, out_funct7,
           out_rs1, out_rs2, out_rd, out_imm, out_alu_op, out_reg_wr_en, out_illegal
  );

  modport slave (
    input  in_valid, in_instr, in_pc, out_ready,
    output in_ready, out_valid, out_pc, out_opcode, out_funct3, out_funct7,
           out_rs1, out_rs2, out_rd, out_imm, out_alu_op, out_reg_wr_en, out_illegal
  );
endinterface

// File: rtl/ex_core_decode_stage.sv
// RV32I decode stage: instruction FIFO, combinational decode of the FIFO head,
// and a registered valid/ready output slot. flush empties both FIFO and slot.
module ex_core_decode_stage #(
  parameter int FIFO_DEPTH = 4,
  parameter int PC_W       = 32
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              flush,
  ex_core_decode_stage_if.slave             bus,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]   occupancy
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + 1);

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IALU   = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_FENCE  = 7'b0001111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  localparam logic [6:0] F7_ZERO = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  typedef enum logic [3:0] {
    ALU_ADD      = 4'd0,
    ALU_SUB      = 4'd1,
    ALU_SLL      = 4'd2,
    ALU_SLT      = 4'd3,
    ALU_SLTU     = 4'd4,
    ALU_XOR      = 4'd5,
    ALU_SRL      = 4'd6,
    ALU_SRA      = 4'd7,
    ALU_OR       = 4'd8,
    ALU_AND      = 4'd9,
    ALU_PASS_IMM = 4'd10
  } alu_op_e;

  logic [31:0]     instr_mem [FIFO_DEPTH];
  logic [PC_W-1:0] pc_mem    [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [CW-1:0]   count;

  logic full;
  logic empty;
  logic push;
  logic load;

  logic [31:0]     head;
  logic [PC_W-1:0] head_pc;
  logic [6:0]      opc;
  logic [2:0]      f3;
  logic [6:0]      f7;
  logic [31:0]     imm_i;
  logic [31:0]     imm_s;
  logic [31:0]     imm_b;
  logic [31:0]     imm_u;
  logic [31:0]     imm_j;

  logic [31:0] dec_imm;
  alu_op_e     dec_alu;
  logic        dec_writes_rd;
  logic        dec_ill;
  logic        dec_wr_en;

  assign full  = (count == CW'(FIFO_DEPTH));
  assign empty = (count == '0);

  // A concurrent pop never frees a slot for a push in the same cycle.
  assign bus.in_ready = !full && !flush;
  assign push         = bus.in_valid && bus.in_ready;
  assign load         = !empty && (!bus.out_valid || bus.out_ready) && !flush;
  assign occupancy    = count;

  assign head    = instr_mem[rd_ptr];
  assign head_pc = pc_mem[rd_ptr];
  assign opc     = head[6:0];
  assign f3      = head[14:12];
  assign f7      = head[31:25];

  assign imm_i = {{20{head[31]}}, head[31:20]};
  assign imm_s = {{20{head[31]}}, head[31:25], head[11:7]};
  assign imm_b = {{19{head[31]}}, head[31], head[7], head[30:25], head[11:8], 1'b0};
  assign imm_u = {head[31:12], 12'b0};
  assign imm_j = {{11{head[31]}}, head[31], head[19:12], head[20], head[30:21], 1'b0};

  // Storage has no reset; validity is carried entirely by count and the pointers.
  always_ff @(posedge clk) begin
    if (push) begin
      instr_mem[wr_ptr] <= bus.in_instr;
      pc_mem[wr_ptr]    <= bus.in_pc;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (load) rd_ptr <= rd_ptr + AW'(1);
      case ({push, load})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_comb begin
    dec_imm       = '0;
    dec_alu       = ALU_ADD;
    dec_writes_rd = 1'b0;
    dec_ill       = 1'b0;
    case (opc)
      OP_R: begin
        dec_writes_rd = 1'b1;
        if (f7 == F7_ZERO) begin
          case (f3)
            3'b000:  dec_alu = ALU_ADD;
            3'b001:  dec_alu = ALU_SLL;
            3'b010:  dec_alu = ALU_SLT;
            3'b011:  dec_alu = ALU_SLTU;
            3'b100:  dec_alu = ALU_XOR;
            3'b101:  dec_alu = ALU_SRL;
            3'b110:  dec_alu = ALU_OR;
            default: dec_alu = ALU_AND;
          endcase
        end else if (f7 == F7_ALT && f3 == 3'b000) begin
          dec_alu = ALU_SUB;
        end else if (f7 == F7_ALT && f3 == 3'b101) begin
          dec_alu = ALU_SRA;
        end else begin
          dec_ill = 1'b1;
        end
      end
      OP_IALU: begin
        dec_writes_rd = 1'b1;
        dec_imm       = imm_i;
        case (f3)
          3'b000: dec_alu = ALU_ADD;
          3'b001: begin
            dec_alu = ALU_SLL;
            if (f7 != F7_ZERO) dec_ill = 1'b1;
          end
          3'b010: dec_alu = ALU_SLT;
          3'b011: dec_alu = ALU_SLTU;
          3'b100: dec_alu = ALU_XOR;
          3'b101: begin
            if (f7 == F7_ZERO)     dec_alu = ALU_SRL;
            else if (f7 == F7_ALT) dec_alu = ALU_SRA;
            else                   dec_ill = 1'b1;
          end
          3'b110:  dec_alu = ALU_OR;
          default: dec_alu = ALU_AND;
        endcase
      end
      OP_LOAD: begin
        dec_writes_rd = 1'b1;
        dec_imm       = imm_i;
        if (f3 == 3'b011 || f3 == 3'b110 || f3 == 3'b111) dec_ill = 1'b1;
      end
      OP_STORE: begin
        dec_imm = imm_s;
        if (f3 > 3'b010) dec_ill = 1'b1;
      end
      OP_BRANCH: begin
        dec_imm = imm_b;
        case (f3)
          3'b000, 3'b001: dec_alu = ALU_SUB;
          3'b100, 3'b101: dec_alu = ALU_SLT;
          3'b110, 3'b111: dec_alu = ALU_SLTU;
          default:        dec_ill = 1'b1;
        endcase
      end
      OP_LUI: begin
        dec_writes_rd = 1'b1;
        dec_imm       = imm_u;
        dec_alu       = ALU_PASS_IMM;
      end
      OP_AUIPC: begin
        dec_writes_rd = 1'b1;
        dec_imm       = imm_u;
      end
      OP_JAL: begin
        dec_writes_rd = 1'b1;
        dec_imm       = imm_j;
      end
      OP_JALR: begin
        dec_writes_rd = 1'b1;
        dec_imm       = imm_i;
        if (f3 != 3'b000) dec_ill = 1'b1;
      end
      OP_FENCE:  dec_imm = '0;
      OP_SYSTEM: dec_imm = imm_i;
      default:   dec_ill = 1'b1;
    endcase
    if (head[1:0] != 2'b11) dec_ill = 1'b1;
  end

  // Illegal instructions still travel downstream, just without a register write.
  assign dec_wr_en = dec_writes_rd && (head[11:7] != 5'd0) && !dec_ill;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.out_valid     <= 1'b0;
      bus.out_pc        <= '0;
      bus.out_opcode    <= '0;
      bus.out_funct3    <= '0;
      bus.out_funct7    <= '0;
      bus.out_rs1       <= '0;
      bus.out_rs2       <= '0;
      bus.out_rd        <= '0;
      bus.out_imm       <= '0;
      bus.out_alu_op    <= '0;
      bus.out_reg_wr_en <= 1'b0;
      bus.out_illegal   <= 1'b0;
    end else if (flush) begin
      bus.out_valid <= 1'b0;
    end else if (load) begin
      bus.out_valid     <= 1'b1;
      bus.out_pc        <= head_pc;
      bus.out_opcode    <= opc;
      bus.out_funct3    <= f3;
      bus.out_funct7    <= f7;
      bus.out_rs1       <= head[19:15];
      bus.out_rs2       <= head[24:20];
      bus.out_rd        <= head[11:7];
      bus.out_imm       <= dec_imm;
      bus.out_alu_op    <= dec_alu;
      bus.out_reg_wr_en <= dec_wr_en;
      bus.out_illegal   <= dec_ill;
    end else if (bus.out_ready) begin
      bus.out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_ex_core_decode_stage.sv
// Testbench for ex_core_decode_stage: queue-level reference model checked every cycle,
// plus directed vectors with hand-computed decode results.
module tb_ex_core_decode_stage;

  localparam int DEPTH = 4;
  localparam int PC_W  = 32;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic       flush = 1'b0;
  logic [2:0] occupancy;

  int total_checks = 0;
  int bad_checks   = 0;

  ex_core_decode_stage_if #(.PC_W(PC_W)) bus ();

  ex_core_decode_stage #(
    .FIFO_DEPTH(DEPTH),
    .PC_W      (PC_W)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .flush    (flush),
    .bus      (bus),
    .occupancy(occupancy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } item_t;

  typedef struct packed {
    logic [31:0] imm;
    logic [3:0]  alu;
    logic        wr;
    logic        ill;
  } dec_t;

  // ALU code for each funct3 of the non-alternate R/I arithmetic group.
  localparam logic [3:0] BASE_OP [8] = '{4'd0, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd8, 4'd9};

  item_t       fifo_q[$];
  item_t       slot;
  bit          slot_valid = 1'b0;
  logic [31:0] pc_next    = 32'h0000_0100;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    total_checks++;
    if (actual !== expected) begin
      bad_checks++;
      $display("[TB] FAIL %s actual=%h expected=%h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic v, input logic [31:0] instr, input logic [31:0] pc,
                               input logic rdy, input logic fl);
    bus.in_valid  = v;
    bus.in_instr  = instr;
    bus.in_pc     = pc;
    bus.out_ready = rdy;
    flush         = fl;
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  function automatic dec_t decodeModel(input logic [31:0] w);
    dec_t               d;
    logic signed [31:0] s;
    logic [31:0]        sx20, sx25, sx31;
    logic [6:0]         op, f7;
    logic [2:0]         f3;
    bit                 writes;
    d      = '0;
    writes = 1'b0;
    s      = w;
    sx20   = s >>> 20;
    sx25   = s >>> 25;
    sx31   = s >>> 31;
    op     = w[6:0];
    f3     = w[14:12];
    f7     = w[31:25];
    case (op)
      7'h33: begin
        writes = 1'b1;
        if (f7 == 7'h00)                   d.alu = BASE_OP[f3];
        else if (f7 == 7'h20 && f3 == 3'd0) d.alu = 4'd1;
        else if (f7 == 7'h20 && f3 == 3'd5) d.alu = 4'd7;
        else                               d.ill = 1'b1;
      end
      7'h13: begin
        writes = 1'b1;
        d.imm  = sx20;
        d.alu  = BASE_OP[f3];
        if (f3 == 3'd1 && f7 != 7'h00) d.ill = 1'b1;
        if (f3 == 3'd5) begin
          if (f7 == 7'h20)      d.alu = 4'd7;
          else if (f7 != 7'h00) d.ill = 1'b1;
        end
      end
      7'h03: begin
        writes = 1'b1;
        d.imm  = sx20;
        d.ill  = (f3 == 3'd3) || (f3 == 3'd6) || (f3 == 3'd7);
      end
      7'h23: begin
        d.imm = (sx25 << 5) | 32'(w[11:7]);
        d.ill = (f3 > 3'd2);
      end
      7'h63: begin
        d.imm = (sx31 << 12) | (32'(w[7]) << 11) | (32'(w[30:25]) << 5) | (32'(w[11:8]) << 1);
        if (f3 < 3'd2)      d.alu = 4'd1;
        else if (f3 < 3'd4) d.ill = 1'b1;
        else if (f3 < 3'd6) d.alu = 4'd3;
        else                d.alu = 4'd4;
      end
      7'h37: begin
        writes = 1'b1;
        d.imm  = w & 32'hFFFF_F000;
        d.alu  = 4'd10;
      end
      7'h17: begin
        writes = 1'b1;
        d.imm  = w & 32'hFFFF_F000;
      end
      7'h6F: begin
        writes = 1'b1;
        d.imm  = (sx31 << 20) | (32'(w[19:12]) << 12) | (32'(w[20]) << 11) | (32'(w[30:21]) << 1);
      end
      7'h67: begin
        writes = 1'b1;
        d.imm  = sx20;
        d.ill  = (f3 != 3'd0);
      end
      7'h0F: d.imm = 32'd0;
      7'h73: d.imm = sx20;
      default: d.ill = 1'b1;
    endcase
    if (w[1:0] != 2'b11) d.ill = 1'b1;
    d.wr = writes && (w[11:7] != 5'd0) && !d.ill;
    return d;
  endfunction

  // Mid-cycle compare against the model, then advance the model for the coming edge.
  always @(negedge clk) begin
    dec_t  e;
    item_t it;
    bit    will_load;
    if (!rst_n) begin
      fifo_q.delete();
      slot_valid = 1'b0;
      checkOutput("rst_out_valid", 32'(bus.out_valid), 32'd0);
      checkOutput("rst_occupancy", 32'(occupancy), 32'd0);
    end else begin
      checkOutput("in_ready", 32'(bus.in_ready), 32'((fifo_q.size() < DEPTH) && !flush));
      checkOutput("occupancy", 32'(occupancy), 32'(fifo_q.size()));
      checkOutput("out_valid", 32'(bus.out_valid), 32'(slot_valid));
      if (slot_valid) begin
        e = decodeModel(slot.instr);
        checkOutput("out_pc", bus.out_pc, slot.pc);
        checkOutput("out_opcode", 32'(bus.out_opcode), 32'(slot.instr[6:0]));
        checkOutput("out_funct3", 32'(bus.out_funct3), 32'(slot.instr[14:12]));
        checkOutput("out_funct7", 32'(bus.out_funct7), 32'(slot.instr[31:25]));
        checkOutput("out_rs1", 32'(bus.out_rs1), 32'(slot.instr[19:15]));
        checkOutput("out_rs2", 32'(bus.out_rs2), 32'(slot.instr[24:20]));
        checkOutput("out_rd", 32'(bus.out_rd), 32'(slot.instr[11:7]));
        checkOutput("out_illegal", 32'(bus.out_illegal), 32'(e.ill));
        checkOutput("out_reg_wr_en", 32'(bus.out_reg_wr_en), 32'(e.wr));
        if (!e.ill) begin
          checkOutput("out_imm", bus.out_imm, e.imm);
          checkOutput("out_alu_op", 32'(bus.out_alu_op), 32'(e.alu));
        end
      end
      will_load = (fifo_q.size() > 0) && (!slot_valid || bus.out_ready);
      if (flush) begin
        fifo_q.delete();
        slot_valid = 1'b0;
      end else begin
        it.instr = bus.in_instr;
        it.pc    = bus.in_pc;
        if (will_load) begin
          slot       = fifo_q.pop_front();
          slot_valid = 1'b1;
        end else if (slot_valid && bus.out_ready) begin
          slot_valid = 1'b0;
        end
        if (bus.in_valid && (fifo_q.size() < DEPTH - (will_load ? 1 : 0))) fifo_q.push_back(it);
      end
    end
  end

  task automatic decodeCase(input string name, input logic [31:0] instr,
                            input int e_rd, input int e_rs1, input int e_rs2,
                            input logic [31:0] e_imm, input int e_alu, input int e_wr, input int e_ill);
    dec_t m;
    int   lat;
    m = decodeModel(instr);
    checkOutput({name, "_model_ill"}, 32'(m.ill), 32'(e_ill));
    checkOutput({name, "_model_wr"}, 32'(m.wr), 32'(e_wr));
    if (e_ill == 0) begin
      checkOutput({name, "_model_imm"}, m.imm, e_imm);
      checkOutput({name, "_model_alu"}, 32'(m.alu), 32'(e_alu));
    end
    applyStimulus(1'b1, instr, pc_next, 1'b1, 1'b0);
    nextCycle();
    applyStimulus(1'b0, 32'd0, 32'd0, 1'b1, 1'b0);
    lat = 0;
    for (int n = 1; n <= 8; n++) begin
      @(negedge clk);
      if (bus.out_valid) begin
        lat = n;
        break;
      end
    end
    checkOutput({name, "_latency"}, 32'(lat), 32'd2);
    checkOutput({name, "_pc"}, bus.out_pc, pc_next);
    checkOutput({name, "_rd"}, 32'(bus.out_rd), 32'(e_rd));
    checkOutput({name, "_rs1"}, 32'(bus.out_rs1), 32'(e_rs1));
    checkOutput({name, "_rs2"}, 32'(bus.out_rs2), 32'(e_rs2));
    checkOutput({name, "_illegal"}, 32'(bus.out_illegal), 32'(e_ill));
    checkOutput({name, "_wr_en"}, 32'(bus.out_reg_wr_en), 32'(e_wr));
    if (e_ill == 0) begin
      checkOutput({name, "_imm"}, bus.out_imm, e_imm);
      checkOutput({name, "_alu"}, 32'(bus.out_alu_op), 32'(e_alu));
    end
    pc_next = pc_next + 32'd4;
    nextCycle();
  endtask

  logic [31:0] mix_tbl [5] = '{32'h40208033, 32'h40315093, 32'h0020E463, 32'h00001117, 32'h000080E7};

  initial begin
    int seen;
    applyStimulus(1'b0, 32'd0, 32'd0, 1'b1, 1'b0);
    rst_n = 1'b0;
    repeat (2) nextCycle();
    checkOutput("reset_out_valid", 32'(bus.out_valid), 32'd0);
    checkOutput("reset_occupancy", 32'(occupancy), 32'd0);
    checkOutput("reset_out_pc", bus.out_pc, 32'd0);
    checkOutput("reset_out_imm", bus.out_imm, 32'd0);
    rst_n = 1'b1;
    #1;
    checkOutput("in_ready_after_reset", 32'(bus.in_ready), 32'd1);
    nextCycle();

    $display("[TB] decode basics");
    decodeCase("add",      32'h003100B3, 1, 2, 3,   32'h0000_0000, 0, 1, 0);
    decodeCase("addi",     32'h00A10093, 1, 2, 10,  32'h0000_000A, 0, 1, 0);
    decodeCase("sw",       32'h00112523, 10, 2, 1,  32'h0000_000A, 0, 0, 0);
    decodeCase("beq",      32'h00208863, 16, 1, 2,  32'h0000_0010, 1, 0, 0);
    decodeCase("addi_neg", 32'hFFF00293, 5, 0, 31,  32'hFFFF_FFFF, 0, 1, 0);
    decodeCase("lui",      32'h123450B7, 1, 8, 3,   32'h1234_5000, 10, 1, 0);
    decodeCase("jal_x0",   32'h0000006F, 0, 0, 0,   32'h0000_0000, 0, 0, 0);
    decodeCase("ill_zero", 32'h00000000, 0, 0, 0,   32'h0000_0000, 0, 0, 1);
    decodeCase("ill_f7",   32'h02000033, 0, 0, 0,   32'h0000_0000, 0, 0, 1);
    decodeCase("ill_ld",   32'h00003003, 0, 0, 0,   32'h0000_0000, 0, 0, 1);

    $display("[TB] back-to-back throughput");
    seen = 0;
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b1, mix_tbl[i], 32'h0000_0800 + 32'(i * 4), 1'b1, 1'b0);
      @(negedge clk);
      if (bus.out_valid) seen++;
      nextCycle();
    end
    applyStimulus(1'b0, 32'd0, 32'd0, 1'b1, 1'b0);
    repeat (4) begin
      @(negedge clk);
      if (bus.out_valid) seen++;
      nextCycle();
    end
    checkOutput("throughput_count", 32'(seen), 32'd5);

    $display("[TB] backpressure");
    for (int i = 0; i < 6; i++) begin
      applyStimulus(1'b1, 32'h00A10093, 32'h0000_1000 + 32'(i * 4), 1'b0, 1'b0);
      nextCycle();
    end
    applyStimulus(1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
    @(negedge clk);
    checkOutput("bp_occupancy", 32'(occupancy), 32'd4);
    checkOutput("bp_in_ready", 32'(bus.in_ready), 32'd0);
    checkOutput("bp_out_pc_held", bus.out_pc, 32'h0000_1000);
    nextCycle();
    applyStimulus(1'b0, 32'd0, 32'd0, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checkOutput("drain_valid", 32'(bus.out_valid), 32'd1);
      checkOutput("drain_pc", bus.out_pc, 32'h0000_1000 + 32'(i * 4));
      nextCycle();
    end
    @(negedge clk);
    checkOutput("drain_empty", 32'(bus.out_valid), 32'd0);
    nextCycle();

    $display("[TB] flush");
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, 32'h003100B3, 32'h0000_2000 + 32'(i * 4), 1'b0, 1'b0);
      nextCycle();
    end
    applyStimulus(1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
    @(negedge clk);
    checkOutput("pre_flush_occupancy", 32'(occupancy), 32'd3);
    nextCycle();
    applyStimulus(1'b1, 32'h00A10093, 32'h0000_2FF0, 1'b1, 1'b1);
    @(negedge clk);
    checkOutput("flush_in_ready", 32'(bus.in_ready), 32'd0);
    nextCycle();
    applyStimulus(1'b0, 32'd0, 32'd0, 1'b1, 1'b0);
    @(negedge clk);
    checkOutput("post_flush_valid", 32'(bus.out_valid), 32'd0);
    checkOutput("post_flush_occupancy", 32'(occupancy), 32'd0);
    nextCycle();
    applyStimulus(1'b1, 32'h00A10093, 32'h0000_3000, 1'b1, 1'b0);
    nextCycle();
    applyStimulus(1'b0, 32'd0, 32'd0, 1'b1, 1'b0);
    @(negedge clk);
    checkOutput("refill_edge1_valid", 32'(bus.out_valid), 32'd0);
    nextCycle();
    @(negedge clk);
    checkOutput("refill_edge2_valid", 32'(bus.out_valid), 32'd1);
    checkOutput("refill_pc", bus.out_pc, 32'h0000_3000);
    nextCycle();

    $display("[TB] reset mid-stream");
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 32'h00112523, 32'h0000_4000 + 32'(i * 4), 1'b0, 1'b0);
      nextCycle();
    end
    applyStimulus(1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
    @(negedge clk);
    checkOutput("pre_reset_occupancy", 32'(occupancy), 32'd2);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("async_reset_valid", 32'(bus.out_valid), 32'd0);
    checkOutput("async_reset_occupancy", 32'(occupancy), 32'd0);
    nextCycle();
    rst_n = 1'b1;
    applyStimulus(1'b0, 32'd0, 32'd0, 1'b1, 1'b0);
    repeat (2) nextCycle();
    checkOutput("after_reset_occupancy", 32'(occupancy), 32'd0);

    $display("test done: total=%0d bad=%0d", total_checks, bad_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired actual=running required=finished");
    $fatal(1, "[TB] watchdog");
  end

endmodule
